transfer_ctrl: RTL
==================

# transfer_ctrl

Sequencing controller for the memory-to-memory transfer datapath. It walks memory A in word pairs and compares each pair. When the first word of a pair is strictly greater than the second, it writes the difference into memory B. Memory B addressing comes from counterB: this block sits directly upstream of counterB, drives its IncB and clear inputs, and reads back AddrB.

## Interface
- AW, 3: memory A address width; memory A depth is 2**AW and must be even.
- DW, 8: data word width for memories A and B.
- clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level request to begin one full transfer; sampled only in IDLE.
- DataA  in  DW  memory A read data (asynchronous read of AddrA).
- AddrB  in  2  current counterB address, used for the write-count check.
- AddrA  out  AW  memory A read address (internal counter).
- ClrB  out  1  one-cycle synchronous clear request to counterB.
- IncB  out  1  counterB increment strobe.
- WEB  out  1  memory B write enable.
- DataB  out  DW  memory B write data = R1 - R2 (unsigned, DW bits).
- WrCnt  out  AW  number of memory B writes in the current transfer.
- Busy  out  1  high in every state except IDLE and DONE.
- Done  out  1  high while in DONE.

## Operation
- Internal registers:
  - R1 and R2, DW bits each.
  - AddrA counter, AW bits, wraps modulo 2**AW.
  - WrCnt, AW bits.
- State transitions:
  - IDLE: if Start=1, go to CLEAR.
  - CLEAR: ClrB=1; AddrA<=0; WrCnt<=0; R1<=0; R2<=0. Go to LOAD1.
  - LOAD1: R1<=DataA; AddrA<=AddrA+1. Go to LOAD2.
  - LOAD2: R2<=DataA; AddrA<=AddrA+1. Go to CMP.
  - CMP: if R1>R2 (unsigned), go to WRITE. Otherwise, if AddrA==0 go to DONE, else go to LOAD1.
  - WRITE: WEB=1; IncB=1; WrCnt<=WrCnt+1. If AddrA==0 go to DONE, else go to LOAD1.
  - DONE: hold until Start=0, then go to IDLE.
- Pair termination: AddrA==0 after LOAD2 means the final pair (addresses 2**AW-2 and 2**AW-1) has been read.
- Write address: WEB and IncB assert in the same cycle. Memory B captures DataB at the AddrB value present before the edge, and counterB advances on that same edge.
- Subtraction: R1>R2 is guaranteed in WRITE, so no underflow occurs. Equal words are not written.
- DataB is driven combinationally as R1-R2 in every state. It is only meaningful while WEB=1.
- AddrB is advisory only. If AddrB==3 and WrCnt!=3 during WRITE, the counterB path is out of sync. The write still proceeds, with no error flag.
- Start asserted while Busy=1 is ignored. Start held high through DONE does not retrigger a transfer; it must drop first.

## Timing
- Reset (Reset=0) forces asynchronously:
  - State: IDLE.
  - Outputs: AddrA=0, R1=0, R2=0, WrCnt=0, ClrB=0, IncB=0, WEB=0, Busy=0, Done=0. DataB=0 follows from R1=R2=0.
- Reset asserted mid-transfer aborts immediately. Memory B keeps any words already written. Leaving reset lands in IDLE.
- Start latency: with Start high at edge N in IDLE, CLEAR is active in cycle N+1, with ClrB and Busy high.
- Per-pair cost: 3 cycles (LOAD1, LOAD2, CMP), plus 1 cycle (WRITE) when R1>R2.
- Total Busy cycles for one transfer = 1 + 3*(2**AW/2) + writes. With AW=3 this is 13 + writes.
- Done rises the cycle after the final CMP or WRITE state.
- Control outputs ClrB, IncB and WEB are Moore outputs, decoded from state only.
- IncB and WEB each last exactly one cycle per write.

## Test plan
- Reset check: drive Reset=0 at any state, mid-LOAD2 included -> all outputs at their reset values within the same cycle; after release, state is IDLE and Done=0.
- Mixed data: A={9,4,2,7,200,100,5,5}, pulse Start -> ClrB one cycle; writes B[0]=5 and B[1]=100; IncB pulses twice; WrCnt=2; Busy high 15 cycles; then Done=1.
- All writes: A={8,1,8,1,8,1,8,1} -> four writes of 7 at AddrB 0,1,2,3; WrCnt=4; Busy high 17 cycles; AddrB wraps to 0 after the last write.
- No writes: A all equal, or each pair ascending -> WEB and IncB never assert; WrCnt=0; Busy high 13 cycles; Done=1.
- Start handling:
  - Hold Start high through the whole transfer and DONE -> no second CLEAR.
  - Drop Start, then re-pulse -> ClrB asserts again; WrCnt and AddrA restart from 0.
- Boundary values: pair (255,0) -> DataB=255 written; pair (0,255) -> skipped; pair (1,0) -> DataB=1.

Source files
------------

// File: rtl/transfer_ctrl.sv
// rtl/transfer_ctrl.sv - pairwise compare-and-subtract sequencer for memory A to memory B transfers
// Walks memory A in word pairs and writes R1-R2 to memory B through counterB when R1>R2.
module transfer_ctrl #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [DW-1:0] DataA,
  input  logic [1:0]    AddrB,
  output logic [AW-1:0] AddrA,
  output logic          ClrB,
  output logic          IncB,
  output logic          WEB,
  output logic [DW-1:0] DataB,
  output logic [AW-1:0] WrCnt,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD1,
    S_LOAD2,
    S_CMP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [DW-1:0] r1_q, r1_d;
  logic [DW-1:0] r2_q, r2_d;

  // counterB desync indication is advisory only; the write proceeds regardless
  logic unused_b_out_of_sync;
  assign unused_b_out_of_sync = (state_q == S_WRITE) && (AddrB == 2'd3) && (wr_cnt_q != AW'(3));

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      wr_cnt_q <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      wr_cnt_q <= wr_cnt_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    wr_cnt_d = wr_cnt_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    ClrB     = 1'b0;
    IncB     = 1'b0;
    WEB      = 1'b0;
    Busy     = 1'b1;
    Done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        ClrB     = 1'b1;
        addr_a_d = '0;
        wr_cnt_d = '0;
        r1_d     = '0;
        r2_d     = '0;
        state_d  = S_LOAD1;
      end
      S_LOAD1: begin
        r1_d     = DataA;
        addr_a_d = addr_a_q + AW'(1);
        state_d  = S_LOAD2;
      end
      S_LOAD2: begin
        r2_d     = DataA;
        addr_a_d = addr_a_q + AW'(1);
        state_d  = S_CMP;
      end
      // AddrA wrapping back to zero marks the final pair as consumed
      S_CMP: begin
        if (r1_q > r2_q)          state_d = S_WRITE;
        else if (addr_a_q == '0)  state_d = S_DONE;
        else                      state_d = S_LOAD1;
      end
      S_WRITE: begin
        WEB      = 1'b1;
        IncB     = 1'b1;
        wr_cnt_d = wr_cnt_q + AW'(1);
        state_d  = (addr_a_q == '0) ? S_DONE : S_LOAD1;
      end
      S_DONE: begin
        Busy = 1'b0;
        Done = 1'b1;
        if (!Start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign AddrA = addr_a_q;
  assign WrCnt = wr_cnt_q;
  assign DataB = r1_q - r2_q;

endmodule
